// File: rtl/ex_mem_stage.sv
// Tessia EX/MEM pipeline boundary: registers the ALU result and control into MEM,
// owns the NZCV flag register, resolves conditional branches and squashes their shadow.
module ex_mem_stage #(
   parameter int N      = 16,
   parameter int RA_W   = 4,
   parameter int PC_W   = 16,
   parameter int SHADOW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic [N-1:0]    alu_result,
   input  logic [3:0]      alu_flags,
   input  logic            set_flags,
   input  logic [2:0]      branch_cond,
   input  logic [PC_W-1:0] branch_target,
   input  logic [N-1:0]    store_data,
   input  logic [RA_W-1:0] rd,
   input  logic            reg_write,
   input  logic            mem_write,
   input  logic            mem_read,
   input  logic            stall,
   input  logic            flush,
   output logic            mem_valid,
   output logic [N-1:0]    mem_alu_result,
   output logic [N-1:0]    mem_store_data,
   output logic [RA_W-1:0] mem_rd,
   output logic            mem_reg_write,
   output logic            mem_mem_write,
   output logic            mem_mem_read,
   output logic [3:0]      flags_q,
   output logic            branch_taken,
   output logic [PC_W-1:0] branch_pc
);

   localparam int              SQ_W       = 3;
   localparam logic [SQ_W-1:0] SHADOW_CNT = SQ_W'(SHADOW);

   localparam logic [2:0] COND_NONE   = 3'b000;
   localparam logic [2:0] COND_ALWAYS = 3'b001;
   localparam logic [2:0] COND_EQ     = 3'b010;
   localparam logic [2:0] COND_NE     = 3'b011;
   localparam logic [2:0] COND_GT     = 3'b100;
   localparam logic [2:0] COND_LT     = 3'b101;
   localparam logic [2:0] COND_GE     = 3'b110;
   localparam logic [2:0] COND_LE     = 3'b111;

   logic [SQ_W-1:0] r_sq_cnt;
   logic [3:0]      r_flags;
   logic            r_branch_taken;
   logic [PC_W-1:0] r_branch_pc;

   logic            r_mem_valid;
   logic [N-1:0]    r_mem_alu_result;
   logic [N-1:0]    r_mem_store_data;
   logic [RA_W-1:0] r_mem_rd;
   logic            r_mem_reg_write;
   logic            r_mem_mem_write;
   logic            r_mem_mem_read;

   logic w_live;
   logic w_acc;
   logic w_squash;
   logic w_cond_true;
   logic w_taken;
   logic w_fn;
   logic w_fz;
   logic w_fv;

   // A live slot is one the pipeline actually advances; the shadow counter decides its fate.
   assign w_live   = ex_valid && !stall && !flush;
   assign w_acc    = w_live && (r_sq_cnt == '0);
   assign w_squash = w_live && (r_sq_cnt != '0);

   // Conditions look only at the committed flags, never at alu_flags of this cycle.
   assign w_fn = r_flags[3];
   assign w_fz = r_flags[2];
   assign w_fv = r_flags[0];

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_cond_true = 1'b0;
      case (branch_cond)
         COND_NONE:   w_cond_true = 1'b0;
         COND_ALWAYS: w_cond_true = 1'b1;
         COND_EQ:     w_cond_true = w_fz;
         COND_NE:     w_cond_true = !w_fz;
         COND_GT:     w_cond_true = !w_fz && (w_fn == w_fv);
         COND_LT:     w_cond_true = (w_fn != w_fv);
         COND_GE:     w_cond_true = (w_fn == w_fv);
         COND_LE:     w_cond_true = w_fz || (w_fn != w_fv);
         default:     w_cond_true = 1'b0;
      endcase
   end

   assign w_taken = w_acc && w_cond_true;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sq_cnt <= '0;
      end else if (flush) begin
         r_sq_cnt <= '0;
      end else if (w_taken) begin
         r_sq_cnt <= SHADOW_CNT;
      end else if (w_squash) begin
         r_sq_cnt <= r_sq_cnt - 1'b1;
      end
   end

   // A flag-setting branch already chose its direction from the old flags above.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flags <= 4'b0000;
      end else if (w_acc && set_flags) begin
         r_flags <= alu_flags;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_branch_taken <= 1'b0;
         r_branch_pc    <= '0;
      end else begin
         r_branch_taken <= w_taken;
         if (w_taken) begin
            r_branch_pc <= branch_target;
         end
      end
   end

   // NOTE: payload registers are reset too, because every output must read zero while rst is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_valid      <= 1'b0;
         r_mem_alu_result <= '0;
         r_mem_store_data <= '0;
         r_mem_rd         <= '0;
         r_mem_reg_write  <= 1'b0;
         r_mem_mem_write  <= 1'b0;
         r_mem_mem_read   <= 1'b0;
      end else if (flush) begin
         r_mem_valid     <= 1'b0;
         r_mem_reg_write <= 1'b0;
         r_mem_mem_write <= 1'b0;
         r_mem_mem_read  <= 1'b0;
      end else if (w_acc) begin
         r_mem_valid      <= 1'b1;
         r_mem_alu_result <= alu_result;
         r_mem_store_data <= store_data;
         r_mem_rd         <= rd;
         r_mem_reg_write  <= reg_write;
         r_mem_mem_write  <= mem_write;
         r_mem_mem_read   <= mem_read;
      end else if (!stall) begin
         r_mem_valid     <= 1'b0;
         r_mem_reg_write <= 1'b0;
         r_mem_mem_write <= 1'b0;
         r_mem_mem_read  <= 1'b0;
      end
   end

   assign mem_valid      = r_mem_valid;
   assign mem_alu_result = r_mem_alu_result;
   assign mem_store_data = r_mem_store_data;
   assign mem_rd         = r_mem_rd;
   // Control bits can never leak out of a bubble.
   assign mem_reg_write  = r_mem_valid & r_mem_reg_write;
   assign mem_mem_write  = r_mem_valid & r_mem_mem_write;
   assign mem_mem_read   = r_mem_valid & r_mem_mem_read;
   assign flags_q        = r_flags;
   assign branch_taken   = r_branch_taken;
   assign branch_pc      = r_branch_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic
// compared against a cycle-level model derived from the stage's architectural rules.
module tb_ex_mem_stage;

   localparam int N      = 16;
   localparam int RA_W   = 4;
   localparam int PC_W   = 16;
   localparam int SHADOW = 2;

   localparam logic [2:0] C_NONE = 3'd0, C_ALW = 3'd1, C_EQ = 3'd2, C_NE = 3'd3;
   localparam logic [2:0] C_GT = 3'd4, C_LT = 3'd5, C_GE = 3'd6, C_LE = 3'd7;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            ex_valid, set_flags, reg_write, mem_write, mem_read, stall, flush;
   logic [N-1:0]    alu_result, store_data;
   logic [3:0]      alu_flags;
   logic [2:0]      branch_cond;
   logic [PC_W-1:0] branch_target;
   logic [RA_W-1:0] rd;

   logic            mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, branch_taken;
   logic [N-1:0]    mem_alu_result, mem_store_data;
   logic [RA_W-1:0] mem_rd;
   logic [3:0]      flags_q;
   logic [PC_W-1:0] branch_pc;

   int checks   = 0;
   int failures = 0;

   // Reference state: what the architecture says is visible after each edge.
   logic [3:0]      m_flags;
   int              m_shadow;
   logic            m_valid, m_rw, m_mw, m_mr, m_bt;
   logic [N-1:0]    m_res, m_sd;
   logic [RA_W-1:0] m_rd;
   logic [PC_W-1:0] m_bpc;

   ex_mem_stage #(.N(N), .RA_W(RA_W), .PC_W(PC_W), .SHADOW(SHADOW)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
      .alu_flags(alu_flags), .set_flags(set_flags), .branch_cond(branch_cond),
      .branch_target(branch_target), .store_data(store_data), .rd(rd),
      .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
      .stall(stall), .flush(flush), .mem_valid(mem_valid),
      .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
      .mem_mem_read(mem_mem_read), .flags_q(flags_q), .branch_taken(branch_taken),
      .branch_pc(branch_pc)
   );

   always #5 clk = ~clk;

   function automatic logic cond_holds(input logic [2:0] c, input logic [3:0] f);
      logic fn, fz, fc, fv;
      {fn, fz, fc, fv} = f;
      case (c)
         C_ALW:   return 1'b1;
         C_EQ:    return fz;
         C_NE:    return !fz;
         C_GT:    return !fz && (fn == fv);
         C_LT:    return fn != fv;
         C_GE:    return fn == fv;
         C_LE:    return fz || (fn != fv);
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_flags = 4'b0; m_shadow = 0; m_valid = 0; m_rw = 0; m_mw = 0; m_mr = 0;
      m_bt = 0; m_res = '0; m_sd = '0; m_rd = '0; m_bpc = '0;
   endtask

   task automatic model_step();
      logic go, taken;
      go    = ex_valid && !stall && !flush && (m_shadow == 0);
      taken = go && cond_holds(branch_cond, m_flags);
      if (flush) begin
         m_valid = 0; m_shadow = 0;
      end else if (go) begin
         m_valid = 1; m_res = alu_result; m_sd = store_data; m_rd = rd;
         m_rw = reg_write; m_mw = mem_write; m_mr = mem_read;
         if (set_flags) m_flags = alu_flags;
         if (taken) begin
            m_shadow = SHADOW; m_bpc = branch_target;
         end
      end else if (!stall) begin
         m_valid = 0;
         if (ex_valid && m_shadow > 0) m_shadow = m_shadow - 1;
      end
      if (!m_valid) begin
         m_rw = 0; m_mw = 0; m_mr = 0;
      end
      m_bt = taken;
   endtask

   task automatic drive_idle();
      ex_valid = 0; alu_result = '0; alu_flags = '0; set_flags = 0; branch_cond = C_NONE;
      branch_target = '0; store_data = '0; rd = '0; reg_write = 0; mem_write = 0;
      mem_read = 0; stall = 0; flush = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_shadow();
      while (m_shadow > 0) begin
         drive_idle(); ex_valid = 1; tick();
      end
      drive_idle();
   endtask

   task automatic load_flags(input logic [3:0] f);
      drive_idle(); ex_valid = 1; set_flags = 1; alu_flags = f; tick();
      drive_idle();
   endtask

   task automatic test_reset();
      drive_idle(); rst = 1; model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, branch_taken} !== 5'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, branch_taken});
      end
      checks++; if (flags_q !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags_q); end
      checks++; if ({mem_alu_result, mem_store_data, mem_rd, branch_pc} !== '0) begin
         failures++; $display("FAIL reset_data got=%h %h %h %h exp=0", mem_alu_result, mem_store_data, mem_rd, branch_pc);
      end
      @(negedge clk); rst = 0;
   endtask

   task automatic test_pipe_through();
      drive_idle(); ex_valid = 1; alu_result = 16'd12322; rd = 4'd3; reg_write = 1; tick();
      checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL pipe_valid got=%b exp=1", mem_valid); end
      checks++; if (mem_alu_result !== 16'd12322) begin failures++; $display("FAIL pipe_result got=%0d exp=12322", mem_alu_result); end
      checks++; if (mem_rd !== 4'd3) begin failures++; $display("FAIL pipe_rd got=%0d exp=3", mem_rd); end
      checks++; if (mem_reg_write !== 1'b1) begin failures++; $display("FAIL pipe_rw got=%b exp=1", mem_reg_write); end
      drive_idle(); tick();
      checks++; if ({mem_valid, mem_reg_write} !== 2'b00) begin failures++; $display("FAIL pipe_bubble got=%b exp=00", {mem_valid, mem_reg_write}); end
   endtask

   task automatic test_cmp_beq();
      logic exp_v [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic ev      [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      drain_shadow();
      load_flags(4'b0100);
      checks++; if (flags_q !== 4'b0100) begin failures++; $display("FAIL beq_flags got=%b exp=0100", flags_q); end
      ex_valid = 1; branch_cond = C_EQ; branch_target = 16'h0040; tick();
      checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b exp=1", branch_taken); end
      checks++; if (branch_pc !== 16'h0040) begin failures++; $display("FAIL beq_pc got=%h exp=0040", branch_pc); end
      checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL beq_enters_mem got=%b exp=1", mem_valid); end
      // Shadow: valid, idle (does not consume), valid, valid -> only the last is accepted.
      for (int i = 0; i < 4; i++) begin
         drive_idle(); ex_valid = ev[i]; reg_write = 1; branch_cond = C_ALW; tick();
         if (i == 0) begin
            checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL beq_pulse got=%b exp=0", branch_taken); end
         end
         checks++; if (mem_valid !== exp_v[i]) begin failures++; $display("FAIL beq_shadow%0d got=%b exp=%b", i, mem_valid, exp_v[i]); end
         checks++; if (mem_reg_write !== exp_v[i]) begin failures++; $display("FAIL beq_shadow_rw%0d got=%b exp=%b", i, mem_reg_write, exp_v[i]); end
      end
      checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL beq_after_shadow got=%b exp=1", branch_taken); end
      drain_shadow();
   endtask

   task automatic test_signed_conds();
      logic [3:0] tf [6] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0100, 4'b0100};
      logic [2:0] tc [6] = '{C_GT, C_LT, C_LT, C_GE, C_LE, C_NE};
      logic       te [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         drain_shadow();
         load_flags(tf[i]);
         ex_valid = 1; branch_cond = tc[i]; branch_target = PC_W'(16'h0100 + i); tick();
         checks++; if (branch_taken !== te[i]) begin
            failures++; $display("FAIL cond%0d flags=%b cond=%0d got=%b exp=%b", i, tf[i], tc[i], branch_taken, te[i]);
         end
      end
      // Flag-setting branch resolves on the old flags (Z=1) while writing Z=0.
      drain_shadow();
      load_flags(4'b0100);
      ex_valid = 1; set_flags = 1; alu_flags = 4'b0000; branch_cond = C_EQ; branch_target = 16'h0200; tick();
      checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL setflag_branch got=%b exp=1", branch_taken); end
      checks++; if (flags_q !== 4'b0000) begin failures++; $display("FAIL setflag_write got=%b exp=0000", flags_q); end
      drain_shadow();
   endtask

   task automatic test_stall();
      logic [PC_W-1:0] pc_before;
      drain_shadow();
      drive_idle(); ex_valid = 1; set_flags = 1; alu_flags = 4'b0100;
      alu_result = 16'h1234; rd = 4'd5; reg_write = 1; tick();
      pc_before = m_bpc;
      drive_idle(); ex_valid = 1; branch_cond = C_EQ; branch_target = 16'h0abc;
      alu_result = 16'h5678; rd = 4'd6; mem_write = 1; stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL stall_bt%0d got=%b exp=0", i, branch_taken); end
         checks++; if ({mem_valid, mem_reg_write, mem_mem_write, mem_alu_result, mem_rd} !== {3'b110, 16'h1234, 4'd5}) begin
            failures++; $display("FAIL stall_mem%0d got=%b%b%b %h %0d exp=110 1234 5", i, mem_valid, mem_reg_write, mem_mem_write, mem_alu_result, mem_rd);
         end
         checks++; if (flags_q !== 4'b0100) begin failures++; $display("FAIL stall_flags%0d got=%b exp=0100", i, flags_q); end
         checks++; if (branch_pc !== pc_before) begin failures++; $display("FAIL stall_pc%0d got=%h exp=%h", i, branch_pc, pc_before); end
      end
      stall = 0; tick();
      checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", branch_taken); end
      checks++; if ({mem_valid, mem_mem_write, mem_alu_result, branch_pc} !== {2'b11, 16'h5678, 16'h0abc}) begin
         failures++; $display("FAIL stall_release_mem got=%b%b %h %h exp=11 5678 0abc", mem_valid, mem_mem_write, mem_alu_result, branch_pc);
      end
      drive_idle(); tick();
      checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL stall_pulse_once got=%b exp=0", branch_taken); end
      drain_shadow();
   endtask

   task automatic test_flush_squash();
      drain_shadow();
      drive_idle(); ex_valid = 1; branch_cond = C_ALW; branch_target = 16'h0777; reg_write = 1; tick();
      checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL flush_setup got=%b exp=1", branch_taken); end
      drive_idle(); ex_valid = 1; reg_write = 1; flush = 1; stall = 1; tick();
      checks++; if ({mem_valid, mem_reg_write, branch_taken} !== 3'b000) begin
         failures++; $display("FAIL flush_clear got=%b exp=000", {mem_valid, mem_reg_write, branch_taken});
      end
      drive_idle(); ex_valid = 1; reg_write = 1; rd = 4'd9; tick();
      checks++; if ({mem_valid, mem_reg_write, mem_rd} !== {2'b11, 4'd9}) begin
         failures++; $display("FAIL flush_next_accept got=%b%b %0d exp=11 9", mem_valid, mem_reg_write, mem_rd);
      end
      checks++; if (branch_pc !== 16'h0777) begin failures++; $display("FAIL flush_pc_hold got=%h exp=0777", branch_pc); end
   endtask

   task automatic test_reset_mid();
      drain_shadow();
      load_flags(4'b1001);
      ex_valid = 1; branch_cond = C_ALW; branch_target = 16'hbeef; reg_write = 1; tick();
      checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL rstmid_setup got=%b exp=1", branch_taken); end
      drive_idle();
      #2 rst = 1;
      #1;
      checks++; if ({mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, branch_taken, flags_q} !== 9'b0) begin
         failures++; $display("FAIL rstmid_ctrl got=%b exp=0", {mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, branch_taken, flags_q});
      end
      checks++; if ({mem_alu_result, mem_store_data, mem_rd, branch_pc} !== '0) begin
         failures++; $display("FAIL rstmid_data got=%h %h %h %h exp=0", mem_alu_result, mem_store_data, mem_rd, branch_pc);
      end
      model_reset();
      @(negedge clk); rst = 0;
      ex_valid = 1; rd = 4'd2; reg_write = 1; tick();
      checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL rstmid_first_accept got=%b exp=1", mem_valid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         ex_valid      = ($urandom_range(0, 3) != 0);
         stall         = ($urandom_range(0, 7) == 0);
         flush         = ($urandom_range(0, 15) == 0);
         set_flags     = $urandom_range(0, 1) != 0;
         alu_flags     = 4'($urandom);
         branch_cond   = 3'($urandom);
         branch_target = PC_W'($urandom);
         alu_result    = N'($urandom);
         store_data    = N'($urandom);
         rd            = RA_W'($urandom);
         reg_write     = $urandom_range(0, 1) != 0;
         mem_write     = $urandom_range(0, 1) != 0;
         mem_read      = $urandom_range(0, 1) != 0;
         tick();
         checks++; if ({mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, flags_q, branch_taken, branch_pc}
                      !== {m_valid, m_rw, m_mw, m_mr, m_flags, m_bt, m_bpc}) begin
            failures++;
            $display("FAIL rand%0d ctrl got=%b%b%b%b f=%b bt=%b pc=%h exp=%b%b%b%b f=%b bt=%b pc=%h", i,
                     mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, flags_q, branch_taken, branch_pc,
                     m_valid, m_rw, m_mw, m_mr, m_flags, m_bt, m_bpc);
         end
         if (m_valid) begin
            checks++; if ({mem_alu_result, mem_store_data, mem_rd} !== {m_res, m_sd, m_rd}) begin
               failures++; $display("FAIL rand%0d data got=%h %h %h exp=%h %h %h", i,
                                    mem_alu_result, mem_store_data, mem_rd, m_res, m_sd, m_rd);
            end
         end
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      model_reset();
      test_reset();
      test_pipe_through();
      test_cmp_beq();
      test_signed_conds();
      test_stall();
      test_flush_squash();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
